status_tx: RTL
==============

# status_tx

Serial transmitter that returns 11-bit status words from the FPGA to the mbed over a three-wire strobe/data/frame link. It is the FPGA-to-mbed counterpart of the instruction receiver that feeds the servo drivers. The top level hands it a word plus a one-cycle `send` request. The block then emits a frame-sync pulse followed by the word MSB-first, and the mbed samples each data bit on the rising edge of the strobe line.

## Interface
- `HALF_PERIOD`, default 50: clk cycles per strobe half-period; legal range 1..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `send`  in  1  request to transmit `tx_data`; sampled only in IDLE.
- `tx_data`  in  11  status word: [10] active, [9] mode, [8] servo select, [7:0] value.
- `tx_frame`  out  1  frame-sync line to the mbed; high during SYNC.
- `tx_set_bit`  out  1  bit strobe; the mbed samples `tx_bit` on its rising edge.
- `tx_bit`  out  1  serial data line.
- `busy`  out  1  high from the cycle after acceptance until the frame ends.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SYNC, LOW, HIGH.
- IDLE:
  - All outputs are 0.
  - On `send`=1, latch `tx_data` into the shift register, load the bit index (N-1, where N=11 or 12), clear the phase counter, and go to SYNC.
- SYNC: `tx_frame`=1, `tx_set_bit`=0, `tx_bit`=0 for 2·HALF_PERIOD cycles, then go to LOW.
- LOW: `tx_set_bit`=0 and `tx_bit`=current shift-register MSB for HALF_PERIOD cycles, then go to HIGH.
- HIGH: `tx_set_bit`=1 and `tx_bit` unchanged for HALF_PERIOD cycles.
  - At the end of HIGH, if the bit index is 0, go to IDLE.
  - Otherwise shift left, decrement the bit index, and go to LOW.
- Bit order is MSB-first: `tx_data[10]` is sent first.
- The latched word is immune to `tx_data` changes after acceptance.
- `send` while `busy`=1 is ignored. Requests are neither queued nor flagged.
- `send` in the cycle `done`=1 is accepted, because the block is in IDLE that cycle.
- The phase counter is 16 bits. It counts 0..limit-1 and resets to 0 on every state change.
- Reset mid-frame:
  - On the cycle after `reset`=1, the block is in IDLE with all outputs 0.
  - No `done` pulse is produced.
  - The partial frame is abandoned. The mbed discards it because no further `tx_frame` is seen.

## Timing
- Reset values: `tx_frame`=0, `tx_set_bit`=0, `tx_bit`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered; none is combinational from inputs.
- Acceptance: `send` is sampled high at edge k. `busy`=1 and `tx_frame`=1 from cycle k+1.
- First bit: `tx_bit` is valid from cycle k+1+2H, where H=HALF_PERIOD. The first `tx_set_bit` rise is at k+1+3H.
- Each bit occupies 2H cycles, and `tx_bit` is stable for H cycles before and H cycles after its strobe rise.
- Frame length: `busy` is high for 2H + N·2H cycles (24H with N=11).
- Completion: in the cycle after the last HIGH phase, `busy`=0, `tx_set_bit`=0, and `done`=1 for exactly one cycle.
- Minimum request-to-request spacing is 24H+1 cycles (26H+1 with parity).

## Configuration
- `STATUS_TX_PARITY_EN` defined:
  - After `tx_data[0]`, one extra bit is sent: even parity, equal to the XOR of `tx_data[10:0]` as latched.
  - N=12, and the frame is 26H cycles.
- `STATUS_TX_PARITY_EN` undefined: N=11, no parity logic is present, and the frame is 24H cycles.

## Test plan
- HALF_PERIOD=2, `send` pulse with `tx_data`=0x5A5 → `busy` high for 48 cycles.
  - `tx_frame` high for cycles 1..4.
  - Values of `tx_bit` at the 11 `tx_set_bit` rises: 1,0,1,1,0,1,0,0,1,0,1.
  - `done` high for one cycle at cycle 49.
- HALF_PERIOD=1 with 0x7FF, then 0x000 → back-to-back frames.
  - The second `send` coincides with the first `done`.
  - The second frame starts immediately: all ones, then all zeros, with no idle gap beyond the `done` cycle.
- HALF_PERIOD=3, `send` with 0x123, then `send` with 0x0FF and `tx_data` changed mid-frame → the transmitted word is 0x123 and the second request is ignored.
- HALF_PERIOD=2, `reset` asserted at cycle 20 of a frame → on the next cycle all outputs are 0 and no `done` occurs. A subsequent `send` of 0x001 transmits correctly.
- With `STATUS_TX_PARITY_EN` defined:
  - `send` 0x001 at HALF_PERIOD=2 → 12 strobes, parity bit 1, `busy` for 52 cycles.
  - `send` 0x401 → parity bit 0.

Source files
------------

// File: rtl/status_tx.sv
// status_tx: serial status-word transmitter; frame-sync pulse, then the word MSB-first on a bit strobe.
// Optional: define STATUS_TX_PARITY_EN to append an even-parity bit after tx_data[0].
module status_tx #(
  parameter int unsigned HALF_PERIOD = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [10:0] tx_data,
  output logic        tx_frame,
  output logic        tx_set_bit,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

`ifdef STATUS_TX_PARITY_EN
  localparam int unsigned N = 12;
`else
  localparam int unsigned N = 11;
`endif

  localparam logic [15:0] PHASE_LAST = 16'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  phase_q, phase_d;
  logic         sync_half_q, sync_half_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] load_word;
  logic [3:0]   idx_q, idx_d;
  logic         frame_q, frame_d;
  logic         set_q, set_d;
  logic         bit_q, bit_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         phase_end;

`ifdef STATUS_TX_PARITY_EN
  assign load_word = {tx_data, ^tx_data};
`else
  assign load_word = tx_data;
`endif

  assign phase_end = (phase_q == PHASE_LAST);

  // Handshake: send is a one-cycle request with no ready line; it is taken only
  // while the FSM is in IDLE (busy low, including the done cycle) and dropped otherwise.
  always_comb begin
    state_d     = state_q;
    phase_d     = 16'(phase_q + 16'd1);
    sync_half_d = sync_half_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (send) begin
          shift_d     = load_word;
          idx_d       = 4'(N - 1);
          sync_half_d = 1'b0;
          state_d     = SYNC;
        end
      end
      // SYNC spans two half-periods so the 16-bit counter never needs 2*H.
      SYNC: begin
        if (phase_end) begin
          phase_d = '0;
          if (sync_half_q) begin
            state_d = LOW;
          end else begin
            sync_half_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          phase_d = '0;
          if (idx_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q - 4'd1;
            state_d = LOW;
          end
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    frame_d = (state_d == SYNC);
    set_d   = (state_d == HIGH);
    bit_d   = ((state_d == LOW) || (state_d == HIGH)) ? shift_d[N-1] : 1'b0;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      sync_half_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      set_q       <= 1'b0;
      bit_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sync_half_q <= sync_half_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      set_q       <= set_d;
      bit_q       <= bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_frame   = frame_q;
  assign tx_set_bit = set_q;
  assign tx_bit     = bit_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule
